// File: rtl/mixcol_pkg.sv
// Shared GF(2^8) helpers, MixColumns coefficients and FSM state encoding
// for the sequential MixColumns / InvMixColumns engine.
package mixcol_pkg;

  // Reduction constant for x^8+x^4+x^3+x+1 after dropping the x^8 term.
  localparam logic [7:0] GF_RED = 8'h1b;

  // Row coefficients, applied to a_r, a_{r+1}, a_{r+2}, a_{r+3}.
  localparam logic [3:0] FWD_C0 = 4'h2;
  localparam logic [3:0] FWD_C1 = 4'h3;
  localparam logic [3:0] FWD_C2 = 4'h1;
  localparam logic [3:0] FWD_C3 = 4'h1;

  localparam logic [3:0] INV_C0 = 4'he;
  localparam logic [3:0] INV_C1 = 4'hb;
  localparam logic [3:0] INV_C2 = 4'hd;
  localparam logic [3:0] INV_C3 = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: XOR of xtime^i(a) for each set bit i of k.
  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mixcol_column.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Row 0 is the most significant byte of the column.
module mixcol_column (
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);
  import mixcol_pkg::*;

  logic [3:0] w_c0, w_c1, w_c2, w_c3;

  assign w_c0 = i_inv ? INV_C0 : FWD_C0;
  assign w_c1 = i_inv ? INV_C1 : FWD_C1;
  assign w_c2 = i_inv ? INV_C2 : FWD_C2;
  assign w_c3 = i_inv ? INV_C3 : FWD_C3;

  // Each output row mixes the four input rows with rotated coefficients.
  always_comb begin
    o_col = '0;
    for (int r = 0; r < 4; r++) begin
      o_col[31-8*r -: 8] = gf_mul4(i_col[31-8*r           -: 8], w_c0)
                         ^ gf_mul4(i_col[31-8*((r+1) % 4) -: 8], w_c1)
                         ^ gf_mul4(i_col[31-8*((r+2) % 4) -: 8], w_c2)
                         ^ gf_mul4(i_col[31-8*((r+3) % 4) -: 8], w_c3);
    end
  end

endmodule

// File: rtl/mixcol_seq_engine.sv
// Sequential MixColumns / InvMixColumns engine: latches a state of NCOL
// columns, transforms one column per clock through a single column unit,
// and holds the result until the consumer takes it.
module mixcol_seq_engine #(
  parameter int NCOL = 4,
  parameter int CW   = $clog2(NCOL) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [32*NCOL-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NCOL-1:0] out_state,
  output logic               busy
);
  import mixcol_pkg::*;

  localparam int SW = 32 * NCOL;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [SW-1:0]   r_src;
  logic [SW-1:0]   r_res;
  logic            r_inv;
  logic            r_rst_q;
  logic            w_accept;
  logic            w_last;
  logic [31:0]     w_col_in;
  logic [31:0]     w_col_out;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_col == CW'(NCOL - 1));
  assign out_state = r_res;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered copy of reset keeps in_ready low for as long as reset is held,
  // without a combinational path from the rst pin.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  // Handshake and status outputs decode the registered state only.
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && !r_rst_q;
    out_valid = (r_state == ST_DONE);
    busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  end

  // Column select from the latched source state.
  always_comb begin
    w_col_in = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (r_col == CW'(c)) w_col_in = r_src[32*(NCOL-c)-1 -: 32];
    end
  end

  mixcol_column u_column (
    .i_col (w_col_in),
    .i_inv (r_inv),
    .o_col (w_col_out)
  );

  // Latch the transfer on acceptance, then write one result column per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_src <= '0;
      r_res <= '0;
      r_inv <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_src <= in_state;
        r_inv <= in_inv;
        r_col <= '0;
      end
    end else if (r_state == ST_RUN) begin
      for (int c = 0; c < NCOL; c++) begin
        if (r_col == CW'(c)) r_res[32*(NCOL-c)-1 -: 32] <= w_col_out;
      end
      r_col <= w_last ? '0 : r_col + CW'(1);
    end
  end

endmodule

// File: tb/tb_mixcol_seq_engine.sv
// Directed and round-trip bench for mixcol_seq_engine at NCOL = 1, 4 and 8.
module tb_mixcol_seq_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [255:0] in_state_w = '0;
  int           sel = 4;

  logic iv1, iv4, iv8;
  logic rdy1, rdy4, rdy8, ov1, ov4, ov8, bz1, bz4, bz8;
  logic [31:0]  os1;
  logic [127:0] os4;
  logic [255:0] os8;

  logic         m_rdy, m_ov, m_bz;
  logic [255:0] m_os;

  int  n_pass = 0;
  int  n_total = 0;
  time t_acc = 0;

  logic [7:0] t2 [256];
  logic [7:0] t3 [256];
  logic [7:0] t9 [256];
  logic [7:0] tb [256];
  logic [7:0] td [256];
  logic [7:0] te [256];

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  always #5 clk = ~clk;

  assign iv1 = in_valid && (sel == 1);
  assign iv4 = in_valid && (sel == 4);
  assign iv8 = in_valid && (sel == 8);

  mixcol_seq_engine #(.NCOL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_inv(in_inv),
    .in_state(in_state_w[31:0]), .out_valid(ov1), .out_ready(out_ready),
    .out_state(os1), .busy(bz1));

  mixcol_seq_engine #(.NCOL(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_inv(in_inv),
    .in_state(in_state_w[127:0]), .out_valid(ov4), .out_ready(out_ready),
    .out_state(os4), .busy(bz4));

  mixcol_seq_engine #(.NCOL(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .in_inv(in_inv),
    .in_state(in_state_w), .out_valid(ov8), .out_ready(out_ready),
    .out_state(os8), .busy(bz8));

  always_comb begin
    case (sel)
      1:       begin m_rdy = rdy1; m_ov = ov1; m_bz = bz1; m_os = {224'b0, os1}; end
      8:       begin m_rdy = rdy8; m_ov = ov8; m_bz = bz8; m_os = os8; end
      default: begin m_rdy = rdy4; m_ov = ov4; m_bz = bz4; m_os = {128'b0, os4}; end
    endcase
  end

  // Generic shift-and-reduce multiply, used only to fill the lookup tables.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [255:0] ref_state(input logic [255:0] d, input int n, input logic inv);
    logic [255:0] r;
    logic [31:0]  cw;
    logic [7:0]   a [4];
    logic [7:0]   b [4];
    r = '0;
    for (int c = 0; c < n; c++) begin
      cw = d[32*(n-c)-1 -: 32];
      for (int k = 0; k < 4; k++) a[k] = cw[31-8*k -: 8];
      for (int k = 0; k < 4; k++) begin
        if (inv)
          b[k] = te[a[k]] ^ tb[a[(k+1)%4]] ^ td[a[(k+2)%4]] ^ t9[a[(k+3)%4]];
        else
          b[k] = t2[a[k]] ^ t3[a[(k+1)%4]] ^ a[(k+2)%4] ^ a[(k+3)%4];
      end
      r[32*(n-c)-1 -: 32] = {b[0], b[1], b[2], b[3]};
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_state(input int n);
    logic [255:0] d;
    logic [255:0] mask;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    mask = (n == 8) ? {256{1'b1}} : ((256'b1 << (32*n)) - 256'b1);
    return d & mask;
  endfunction

  // Offer one state, disturb the inputs after acceptance, and wait for out_valid.
  // Returns at the negedge where out_valid is first seen, with lat in cycles.
  task automatic xfer(input int s, input logic [255:0] d, input logic inv,
                      output logic [255:0] res, output int lat);
    sel = s;
    @(negedge clk);
    in_state_w = d;
    in_inv     = inv;
    in_valid   = 1'b1;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid   = 1'b0;
    in_inv     = ~inv;
    in_state_w = ~d;
    lat = 0;
    while (m_ov !== 1'b1 && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    res = m_os;
  endtask

  task automatic test_reset;
    sel = 4;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (m_rdy !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", m_rdy); else n_pass++;
    n_total++; if (m_ov !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", m_ov); else n_pass++;
    n_total++; if (m_bz !== 1'b0) $display("FAIL reset_busy: got %b want 0", m_bz); else n_pass++;
    n_total++; if (m_os !== '0) $display("FAIL reset_out_state: got %h want 0", m_os); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (m_rdy !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", m_rdy); else n_pass++;
  endtask

  task automatic test_forward;
    logic [255:0] res;
    int lat;
    out_ready = 1'b1;
    xfer(4, {128'b0, FWD_IN}, 1'b0, res, lat);
    n_total++; if (res !== {128'b0, FWD_OUT}) $display("FAIL fwd4_state: got %h want %h", res, FWD_OUT); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL fwd4_latency: got %0d want 4", lat); else n_pass++;
    xfer(1, {224'b0, FWD_IN[127:96]}, 1'b0, res, lat);
    n_total++; if (res !== {224'b0, FWD_OUT[127:96]}) $display("FAIL fwd1_state: got %h want %h", res, FWD_OUT[127:96]); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL fwd1_latency: got %0d want 1", lat); else n_pass++;
    xfer(8, {FWD_IN, INV_OUT}, 1'b0, res, lat);
    n_total++; if (res !== {FWD_OUT, INV_IN}) $display("FAIL fwd8_state: got %h want %h", res, {FWD_OUT, INV_IN}); else n_pass++;
    n_total++; if (lat !== 8) $display("FAIL fwd8_latency: got %0d want 8", lat); else n_pass++;
  endtask

  task automatic test_inverse;
    logic [255:0] res;
    int lat;
    out_ready = 1'b1;
    xfer(4, {128'b0, INV_IN}, 1'b1, res, lat);
    n_total++; if (res !== {128'b0, INV_OUT}) $display("FAIL inv4_state: got %h want %h", res, INV_OUT); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL inv4_latency: got %0d want 4", lat); else n_pass++;
  endtask

  task automatic test_roundtrip;
    logic [255:0] d, r1, r2;
    int lat;
    int ns [3];
    ns[0] = 1; ns[1] = 4; ns[2] = 8;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int it = 0; it < 2; it++) begin
        d = rand_state(ns[j]);
        xfer(ns[j], d, 1'b0, r1, lat);
        n_total++; if (r1 !== ref_state(d, ns[j], 1'b0)) $display("FAIL rt_fwd_n%0d: got %h want %h", ns[j], r1, ref_state(d, ns[j], 1'b0)); else n_pass++;
        xfer(ns[j], r1, 1'b1, r2, lat);
        n_total++; if (r2 !== ref_state(r1, ns[j], 1'b1)) $display("FAIL rt_inv_n%0d: got %h want %h", ns[j], r2, ref_state(r1, ns[j], 1'b1)); else n_pass++;
        n_total++; if (r2 !== d) $display("FAIL rt_orig_n%0d: got %h want %h", ns[j], r2, d); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] res;
    int lat;
    out_ready = 1'b0;
    xfer(4, {128'b0, FWD_IN}, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid   = (i >= 3 && i <= 5);
      in_state_w = {8{$urandom}};
      n_total++; if (m_ov !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", i, m_ov); else n_pass++;
      n_total++; if (m_os !== {128'b0, FWD_OUT}) $display("FAIL bp_out_state[%0d]: got %h want %h", i, m_os, FWD_OUT); else n_pass++;
      n_total++; if (m_rdy !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, m_rdy); else n_pass++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (m_ov !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", m_ov); else n_pass++;
    n_total++; if (m_rdy !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", m_rdy); else n_pass++;
    n_total++; if (m_bz !== 1'b0) $display("FAIL bp_release_busy: got %b want 0", m_bz); else n_pass++;
    n_total++; if (m_os !== {128'b0, FWD_OUT}) $display("FAIL bp_result_held: got %h want %h", m_os, FWD_OUT); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [255:0] res;
    int lat;
    sel = 4;
    out_ready = 1'b1;
    @(negedge clk);
    in_state_w = {128'b0, INV_IN};
    in_inv     = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (m_bz !== 1'b1 || m_ov !== 1'b0) $display("FAIL rstmid_running: got busy=%b valid=%b want busy=1 valid=0", m_bz, m_ov); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (m_bz !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", m_bz); else n_pass++;
    n_total++; if (m_ov !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", m_ov); else n_pass++;
    n_total++; if (m_os !== '0) $display("FAIL rstmid_out_state: got %h want 0", m_os); else n_pass++;
    n_total++; if (m_rdy !== 1'b0) $display("FAIL rstmid_in_ready: got %b want 0", m_rdy); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (m_rdy !== 1'b1) $display("FAIL rstmid_ready_after: got %b want 1", m_rdy); else n_pass++;
    xfer(4, {128'b0, INV_IN}, 1'b1, res, lat);
    n_total++; if (res !== {128'b0, INV_OUT}) $display("FAIL rstmid_next_xfer: got %h want %h", res, INV_OUT); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [255:0] res;
    int  lat;
    time t_prev;
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) xfer(4, {128'b0, FWD_IN}, 1'b0, res, lat);
      else            xfer(4, {128'b0, INV_IN}, 1'b1, res, lat);
      n_total++;
      if (res !== {128'b0, ((i % 2 == 0) ? FWD_OUT : INV_OUT)})
        $display("FAIL b2b_state[%0d]: got %h want %h", i, res, ((i % 2 == 0) ? FWD_OUT : INV_OUT));
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (t_acc - t_prev !== time'(60)) $display("FAIL b2b_interval[%0d]: got %0t want 60", i, t_acc - t_prev);
        else n_pass++;
      end
      t_prev = t_acc;
    end
  endtask

  initial begin
    for (int v = 0; v < 256; v++) begin
      t2[v] = gmul(8'(v), 8'h02);
      t3[v] = gmul(8'(v), 8'h03);
      t9[v] = gmul(8'(v), 8'h09);
      tb[v] = gmul(8'(v), 8'h0b);
      td[v] = gmul(8'(v), 8'h0d);
      te[v] = gmul(8'(v), 8'h0e);
    end
    test_reset;
    test_forward;
    test_inverse;
    test_roundtrip;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
